// File: rtl/sys_bridge_n_pkg.sv
// sys_bridge_pkg: shared control-window offsets and decode constants for sys_bridge_n.
package sys_bridge_pkg;
  typedef enum logic [1:0] {
    OFF_IM      = 2'd0,
    OFF_PEND    = 2'd1,
    OFF_ERRCNT  = 2'd2,
    OFF_ERRADDR = 2'd3
  } ctl_off_e;
  localparam int WIN_BYTES = 16;
  localparam int WIN_LSB = $clog2(WIN_BYTES);
  localparam logic [31:0] UNMAPPED_RD = 32'hffff_ffff;
  localparam logic [11:0] BASE_HI_DEF = 12'h7f0;
endpackage

// File: rtl/sys_bridge_n_if.sv
// sys_bridge_n_if: CPU data port and device-side bus of the system bridge.
interface sys_bridge_n_if #(parameter int N_DEV = 2);
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic cpu_we;
  logic cpu_re;
  logic [31:0] cpu_rdata;
  logic cpu_rvalid;
  logic [5:0] cpu_hwint;
  logic bus_err;
  logic [1:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [N_DEV-1:0] dev_we;
  logic [32*N_DEV-1:0] dev_rdata;
  logic [N_DEV-1:0] dev_irq;
  modport slave (
    input cpu_addr, cpu_wdata, cpu_we, cpu_re, dev_rdata, dev_irq,
    output cpu_rdata, cpu_rvalid, cpu_hwint, bus_err, dev_addr, dev_wdata, dev_we
  );
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, dev_rdata, dev_irq,
    input cpu_rdata, cpu_rvalid, cpu_hwint, bus_err, dev_addr, dev_wdata, dev_we
  );
endinterface

// File: rtl/sys_bridge_n_irq_ch.sv
// bridge_irq_ch: one interrupt channel; level mode follows the sampled line,
// edge mode latches rising edges until a W1C clear, with set winning over clear.
module bridge_irq_ch #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  input  logic clr_i,
  output logic pend_o
);
  logic irq_q, pend_q, pend_d;
  assign pend_d = EDGE ? (irq_i & ~irq_q) | (pend_q & ~clr_i) : irq_i;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
    end
  end
  assign pend_o = pend_q;
endmodule

// File: rtl/sys_bridge_n.sv
// sys_bridge_n: decodes 16-byte device windows plus one control window,
// registers read data, masks device interrupts and logs unmapped accesses.
module sys_bridge_n
  import sys_bridge_pkg::*;
#(
  parameter int N_DEV = 2,
  parameter logic [11:0] BASE_HI = BASE_HI_DEF,
  parameter logic [5:0] IRQ_EDGE = 6'b000000
) (
  input logic clk,
  input logic reset,
  sys_bridge_n_if.slave bus
);
  logic [11:0] idx;
  logic dev_hit, ctl_hit, err, ctl_we;
  ctl_off_e off;
  logic [N_DEV-1:0] im_q, im_d, pend, clr;
  logic [31:0] errcnt_q, errcnt_d, erraddr_q, rdata_q, rdata_d, dev_rd, ctl_rd;
  logic rvalid_q, bus_err_q;
  logic [5:0] hwint_q;
  assign idx = bus.cpu_addr[15:WIN_LSB] - BASE_HI;
  assign dev_hit = idx < 12'(N_DEV);
  assign ctl_hit = idx == 12'(N_DEV);
  assign err = (bus.cpu_we | bus.cpu_re) & ~dev_hit & ~ctl_hit;
  assign ctl_we = bus.cpu_we & ctl_hit;
  assign off = ctl_off_e'(bus.cpu_addr[3:2]);
  always_comb begin
    dev_rd = '0;
    for (int i = 0; i < N_DEV; i++) if (idx == 12'(i)) dev_rd = bus.dev_rdata[32*i +: 32];
    ctl_rd = off == OFF_IM ? 32'(im_q) : off == OFF_PEND ? 32'(pend) :
             off == OFF_ERRCNT ? errcnt_q : erraddr_q;
    rdata_d = bus.cpu_re ? (dev_hit ? dev_rd : ctl_hit ? ctl_rd : UNMAPPED_RD) : rdata_q;
    im_d = ctl_we && off == OFF_IM ? bus.cpu_wdata[N_DEV-1:0] : im_q;
    clr = ctl_we && off == OFF_PEND ? bus.cpu_wdata[N_DEV-1:0] : '0;
    // clear first, then count, so a coincident error leaves the counter at 1
    errcnt_d = ctl_we && off == OFF_ERRCNT ? '0 : errcnt_q;
    errcnt_d = err && errcnt_d != '1 ? errcnt_d + 32'd1 : errcnt_d;
  end
  for (genvar i = 0; i < N_DEV; i++) begin : g_ch
    assign bus.dev_we[i] = bus.cpu_we & (idx == 12'(i));
    bridge_irq_ch #(.EDGE(IRQ_EDGE[i])) u_ch (
      .clk    (clk),
      .reset  (reset),
      .irq_i  (bus.dev_irq[i]),
      .clr_i  (clr[i]),
      .pend_o (pend[i])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q      <= '1;
      errcnt_q  <= '0;
      erraddr_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      hwint_q   <= '0;
    end else begin
      im_q      <= im_d;
      errcnt_q  <= errcnt_d;
      erraddr_q <= err ? bus.cpu_addr : erraddr_q;
      rdata_q   <= rdata_d;
      rvalid_q  <= bus.cpu_re;
      bus_err_q <= err;
      hwint_q   <= 6'(pend & im_q);
    end
  end
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_hwint = hwint_q;
  assign bus.bus_err = bus_err_q;
  assign bus.dev_addr = bus.cpu_addr[3:2];
  assign bus.dev_wdata = bus.cpu_wdata;
endmodule

// File: doc/sys_bridge_n.md
Name: sys_bridge_n

Overview:
- Parametrised system bridge between the MIPS CPU data port and N memory-mapped peripherals (timers and later devices).
- Decodes 16-byte device windows and drives per-device write enables.
- Registers read data (1-cycle latency), latches and masks device interrupts into CPU_HWint[7:2], and detects unmapped accesses.
- Owns a control window holding the interrupt mask, pending bits and bus-error log.

Parameters:
- N_DEV, 2, number of device windows (1..6); device i occupies addr[15:4] == BASE_HI + i.
- BASE_HI, 12'h7f0, window index of device 0.
- IRQ_EDGE, 6'b000000, per-channel mode: bit i = 1 means edge-triggered (rising), 0 means level.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  CPU byte address; only [15:2] decoded.
- cpu_wdata  in  32  CPU write data.
- cpu_we  in  1  CPU write strobe, single cycle.
- cpu_re  in  1  CPU read strobe, single cycle.
- cpu_rdata  out  32  registered read data.
- cpu_rvalid  out  1  high one cycle after an accepted cpu_re.
- cpu_hwint  out  6  interrupt lines for Cause[15:10]/HWint[7:2].
- bus_err  out  1  one-cycle pulse on an unmapped access.
- dev_addr  out  2  cpu_addr[3:2], combinational.
- dev_wdata  out  32  cpu_wdata, combinational.
- dev_we  out  N_DEV  one-hot write enable, combinational.
- dev_rdata  in  32*N_DEV  device read data; slice i belongs to device i.
- dev_irq  in  N_DEV  device interrupt requests, synchronous to clk.

Behaviour:
- Decode:
  - idx = cpu_addr[15:4] - BASE_HI.
  - Device hit when idx < N_DEV.
  - Control hit when idx == N_DEV.
  - All other addresses are unmapped.
- dev_we[i] = cpu_we & hit(i), combinational, same cycle.
- Control writes and unmapped writes assert no dev_we.
- Control window registers, offset by cpu_addr[3:2]:
  - 0: IM[N_DEV-1:0], read/write.
  - 1: PEND, read-only; a write clears PEND bits where wdata=1 (edge channels only).
  - 2: ERRCNT, 32-bit read-only; a write of any value clears it.
  - 3: ERRADDR, read-only; last unmapped address.
  - Unused upper bits read as 0.
- Read path:
  - On the clk edge with cpu_re=1, the selected data is captured into cpu_rdata and cpu_rvalid=1 for exactly one cycle.
  - Device hit returns dev_rdata slice. Control hit returns the register value before any same-cycle write. Unmapped returns 32'hffff_ffff.
  - When cpu_re=0, cpu_rdata holds its value and cpu_rvalid=0.
- Interrupts:
  - irq_q <= dev_irq every cycle.
  - Level channel: PEND[i] = irq_q[i].
  - Edge channel: PEND[i] sets when dev_irq[i] & ~irq_q[i]. It clears on a W1C write. Set wins over clear in the same cycle.
  - cpu_hwint = zero-extend(PEND & IM) to 6 bits, registered output; 1 cycle latency from PEND.
- Bus error:
  - Any cpu_we or cpu_re to an unmapped address pulses bus_err the next cycle.
  - The same access captures ERRADDR <= cpu_addr and increments ERRCNT, saturating at 32'hffff_ffff.
  - A same-cycle error and ERRCNT clear results in ERRCNT = 1.
- Simultaneous cpu_we and cpu_re: both are performed; the read returns pre-write data.
- Reset (async, immediate): cpu_rdata=0, cpu_rvalid=0, cpu_hwint=0, bus_err=0, IM=all ones, PEND=0, irq_q=0, ERRCNT=0, ERRADDR=0. Reset asserted mid-read kills cpu_rvalid.

Decomposition:
- Package sys_bridge_pkg holds:
  - control offsets: IM=2'd0, PEND=2'd1, ERRCNT=2'd2, ERRADDR=2'd3;
  - window size 16;
  - unmapped read value 32'hffff_ffff;
  - default BASE_HI.
- Sub-module bridge_irq_ch, one per channel, instantiated by generate: a per-channel pending flop with level/edge mode, W1C and set-priority.

Test Plan:
- Write 0x1234 to 0x7f04 (N_DEV=2) -> dev_we=2'b01, dev_addr=1 in the same cycle. Read 0x7f14 with dev_rdata[63:32]=0xABCD -> cpu_rdata=0xABCD, cpu_rvalid=1 one cycle later.
- Read 0x7f30 (unmapped) -> cpu_rdata=0xffffffff and bus_err pulse. Then read 0x7f28 -> ERRCNT=1; read 0x7f2c -> 0x7f30.
- Level IRQ1 high with IM=2'b11 -> cpu_hwint=6'b000010 two cycles after. Write IM=0 at 0x7f20 -> cpu_hwint=0. IRQ1 low -> PEND[1]=0.
- IRQ_EDGE=1: one-cycle pulse on dev_irq[0] -> PEND[0] stays 1. Write 1 to 0x7f24 -> PEND[0]=0. A new edge in the same cycle as the clear -> PEND[0]=1.
- Force ERRCNT to saturation via 0xffffffff+2 unmapped accesses -> holds 0xffffffff.
- Assert reset mid-read and mid-pending -> all outputs 0 at once and IM reads back 0x3.
